// File: rtl/filter_loader_pkg.sv
// Shared constants and FSM encoding for the 4x4 filter loader.
// The row index width is derived from the filter dimension.
package filter_loader_pkg;

  localparam int FILT_DIM    = 4;
  localparam int FILT_WORD_W = 32;
  localparam int ROW_W       = $clog2(FILT_DIM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/filter_loader.sv
// Fetches filter rows 0..last_row from word memory, one request per row.
// Each returned row is presented to the 4x4 filter buffer as a one-cycle write.
module filter_loader
  import filter_loader_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ROW_W-1:0]       last_row,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [FILT_WORD_W-1:0] mem_data,
  output logic                   buf_ld,
  output logic [ROW_W-1:0]       buf_row,
  output logic [FILT_WORD_W-1:0] buf_data
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ROW_STRIDE);

  state_t            state;
  state_t            state_nxt;
  logic [ROW_W-1:0]  row_q;
  logic [ROW_W-1:0]  last_q;
  logic [ADDR_W-1:0] base_q;
  logic              row_is_last;
  logic [ADDR_W-1:0] rd_addr;

  assign row_is_last = (row_q == last_q);
  // Wraps modulo 2^ADDR_W by construction of the operand widths.
  assign rd_addr     = base_q + ADDR_W'(row_q) * STRIDE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (mem_ack) state_nxt = WRITE;
      WRITE:   state_nxt = row_is_last ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    buf_ld   = 1'b0;
    case (state)
      REQ: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = rd_addr;
      end
      WRITE: begin
        busy   = 1'b1;
        buf_ld = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Row counter, captured request and buffer write registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= '0;
      last_q   <= '0;
      base_q   <= '0;
      buf_row  <= '0;
      buf_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base_q <= base_addr;
          last_q <= last_row;
          row_q  <= '0;
        end
        REQ: if (mem_ack) begin
          buf_row  <= row_q;
          buf_data <= mem_data;
        end
        WRITE: if (!row_is_last) row_q <= row_q + ROW_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_loader.sv
// Scoreboard bench for filter_loader: stimulus pushes expected addresses,
// buffer writes and done cycles; a negedge monitor pops and compares them.
module tb_filter_loader;
  import filter_loader_pkg::*;

  localparam int ADDR_W = 16;

  typedef struct packed {
    logic [1:0]  row;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              sel;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        last_row;
  logic              mem_ack;
  logic [31:0]       mem_data;

  logic busy1, done1, mem_rd1, buf_ld1;
  logic busy2, done2, mem_rd2, buf_ld2;
  logic [ADDR_W-1:0] mem_addr1, mem_addr2;
  logic [1:0]        buf_row1, buf_row2;
  logic [31:0]       buf_data1, buf_data2;

  int  cyc = 0;
  int  n_total = 0;
  int  n_pass = 0;
  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int                exp_done[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  filter_loader #(.ADDR_W(ADDR_W), .ROW_STRIDE(1)) dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .base_addr(base_addr),
    .last_row(last_row), .busy(busy1), .done(done1), .mem_rd(mem_rd1),
    .mem_addr(mem_addr1), .mem_ack(mem_ack), .mem_data(mem_data),
    .buf_ld(buf_ld1), .buf_row(buf_row1), .buf_data(buf_data1)
  );

  filter_loader #(.ADDR_W(ADDR_W), .ROW_STRIDE(8)) dut2 (
    .clk(clk), .rst(rst), .start(start & sel), .base_addr(base_addr),
    .last_row(last_row), .busy(busy2), .done(done2), .mem_rd(mem_rd2),
    .mem_addr(mem_addr2), .mem_ack(mem_ack), .mem_data(mem_data),
    .buf_ld(buf_ld2), .buf_row(buf_row2), .buf_data(buf_data2)
  );

  // Selected DUT is observed; the other one must stay silent.
  logic              m_busy, m_done, m_rd, m_ld, o_ld, o_done;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_row;
  logic [31:0]       m_data;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;
  assign m_rd   = sel ? mem_rd2 : mem_rd1;
  assign m_ld   = sel ? buf_ld2 : buf_ld1;
  assign m_addr = sel ? mem_addr2 : mem_addr1;
  assign m_row  = sel ? buf_row2 : buf_row1;
  assign m_data = sel ? buf_data2 : buf_data1;
  assign o_ld   = sel ? buf_ld1 : buf_ld2;
  assign o_done = sel ? done1 : done2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_total++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  logic              prev_rd = 1'b0;
  logic              prev_ack = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (m_rd && mem_ack) begin
      if (exp_addr.size() == 0) fail_event("mem_addr unexpected ack");
      else begin
        check("mem_addr", m_addr, exp_addr[0]);
        void'(exp_addr.pop_front());
      end
    end
    if (m_rd && prev_rd && !prev_ack) check("addr_stable", m_addr, prev_addr);
    if (m_ld) begin
      if (exp_wr.size() == 0) fail_event("buf_ld unexpected");
      else begin
        check("buf_row", m_row, exp_wr[0].row);
        check("buf_data", m_data, exp_wr[0].data);
        void'(exp_wr.pop_front());
      end
    end
    if (m_done) begin
      check("busy_at_done", m_busy, 0);
      if (exp_done.size() == 0) fail_event("done unexpected");
      else begin
        check("done_cycle", cyc, exp_done[0]);
        void'(exp_done.pop_front());
      end
    end
    if (o_ld || o_done) fail_event("unselected dut active");
    prev_rd   <= m_rd;
    prev_ack  <= mem_ack;
    prev_addr <= m_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [1:0] lr,
                          input bit expect_done, input int extra_wait);
    base_addr = b;
    last_row  = lr;
    start     = 1'b1;
    if (expect_done) exp_done.push_back(cyc + 2 * (int'(lr) + 1) + 1 + extra_wait);
    tick();
    start = 1'b0;
  endtask

  task automatic serve(input logic [15:0] addr, input logic [1:0] row,
                       input logic [31:0] d, input int wait_c, output int rd_cycles);
    int t = 0;
    exp_addr.push_back(addr);
    exp_wr.push_back(wr_t'{row: row, data: d});
    rd_cycles = 0;
    while (!m_rd && t < 20) begin
      tick();
      t++;
    end
    check("mem_rd_seen", m_rd, 1);
    for (int i = 0; i < wait_c; i++) begin
      if (m_rd) rd_cycles++;
      tick();
    end
    if (m_rd) rd_cycles++;
    check("busy_in_req", m_busy, 1);
    mem_ack  = 1'b1;
    mem_data = d;
    tick();
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    check("mem_rd_drop", m_rd, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (m_busy && t < 50) begin
      tick();
      t++;
    end
    check("load_finished", m_busy, 0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int rc;
    rst = 1'b1; start = 1'b1; sel = 1'b0;
    base_addr = 16'h1234; last_row = 2'd3; mem_ack = 1'b0; mem_data = 32'h0;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_mem_rd", mem_rd1, 0);
    check("rst_mem_addr", mem_addr1, 0);
    check("rst_buf_ld", buf_ld1, 0);
    check("rst_buf_row", buf_row1, 0);
    check("rst_buf_data", buf_data1, 0);
    check("rst_state", dut.state, IDLE);
    tick();

    // Four rows, zero-wait memory.
    do_start(16'h0100, 2'd3, 1'b1, 0);
    serve(16'h0100, 2'd0, 32'h01020304, 0, rc);
    serve(16'h0101, 2'd1, 32'h11121314, 0, rc);
    serve(16'h0102, 2'd2, 32'h21222324, 0, rc);
    serve(16'h0103, 2'd3, 32'h31323334, 0, rc);
    wait_idle();
    check("buf_row_hold", buf_row1, 3);
    check("buf_data_hold", buf_data1, 32'h31323334);

    // Single row, acknowledge delayed by three cycles.
    do_start(16'h2000, 2'd0, 1'b1, 3);
    serve(16'h2000, 2'd0, 32'hA5A55A5A, 3, rc);
    check("rd_cycles", rc, 4);
    wait_idle();

    // Stride 8 with address wrap.
    sel = 1'b1;
    tick();
    do_start(16'hFFF8, 2'd1, 1'b1, 0);
    serve(16'hFFF8, 2'd0, 32'hDEADBEEF, 0, rc);
    serve(16'h0000, 2'd1, 32'hCAFEF00D, 0, rc);
    wait_idle();
    sel = 1'b0;
    tick();

    // Restart request and stray acknowledge while writing.
    do_start(16'h0040, 2'd2, 1'b1, 0);
    serve(16'h0040, 2'd0, 32'h10203040, 0, rc);
    mem_ack = 1'b1; mem_data = 32'hBAD0BAD0;
    start = 1'b1; base_addr = 16'h9999; last_row = 2'd3;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0; start = 1'b0;
    serve(16'h0041, 2'd1, 32'h50607080, 0, rc);
    serve(16'h0042, 2'd2, 32'h90A0B0C0, 0, rc);
    wait_idle();

    // Reset while requesting row 2, then a stale acknowledge, then a fresh load.
    do_start(16'h0300, 2'd3, 1'b0, 0);
    serve(16'h0300, 2'd0, 32'h0A0B0C0D, 0, rc);
    serve(16'h0301, 2'd1, 32'h1A1B1C1D, 0, rc);
    tick();
    check("req_before_rst", mem_rd1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_done", done1, 0);
    check("mid_rst_mem_rd", mem_rd1, 0);
    check("mid_rst_mem_addr", mem_addr1, 0);
    check("mid_rst_buf_ld", buf_ld1, 0);
    check("mid_rst_buf_row", buf_row1, 0);
    check("mid_rst_buf_data", buf_data1, 0);
    check("mid_rst_state", dut.state, IDLE);
    mem_ack = 1'b1; mem_data = 32'hFFFFFFFF;
    tick(); tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    check("stale_ack_rd", mem_rd1, 0);
    check("stale_ack_busy", busy1, 0);
    do_start(16'h0500, 2'd1, 1'b1, 0);
    serve(16'h0500, 2'd0, 32'h0F0E0D0C, 0, rc);
    serve(16'h0501, 2'd1, 32'h1B1A1918, 0, rc);
    wait_idle();

    check("exp_addr_left", exp_addr.size(), 0);
    check("exp_wr_left", exp_wr.size(), 0);
    check("exp_done_left", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
